mux_rr_sched: RTL and testbench
===============================

MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 SHALL have parameter NCH, default 8: number of requesters and mux inputs; fixed at 8 in this release.
REQ-002 SHALL have parameter MAX_HOLD, default 16: maximum grant length in cycles when timeout is compiled in; legal range 2..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 8: per-channel request levels.
REQ-006 SHALL have port done, input, 1: release pulse from the granted channel.
REQ-007 SHALL have port d, input, 8: data inputs; d[i] belongs to channel i.
REQ-008 SHALL have port gnt, output, 8: one-hot grant vector, or all zero.
REQ-009 SHALL have port sel, output, 3: binary index of the granted channel, driving the 8:1 mux select (sel[2] MSB).
REQ-010 SHALL have port valid, output, 1: high while any grant is held.
REQ-011 SHALL have port y, output, 1: registered mux output.
REQ-012 SHALL have port timeout, output, 1: one-cycle pulse on a forced release.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 IDLE with req != 0 SHALL grant, at the next edge, the first set req bit at or after rotating pointer ptr, searching upward mod 8; the FSM then enters BUSY.
REQ-015 Grant latency SHALL be exactly 1 cycle from req sampled in IDLE to gnt/sel/valid asserted.
REQ-016 In BUSY, gnt, sel and valid SHALL stay stable until release.
REQ-017 Release SHALL occur when done=1, or when req[sel]=0; on release, gnt=0 and valid=0 at the next edge, the FSM returns to IDLE, and ptr=(sel+1) mod 8.
REQ-018 Pointer wrap SHALL be 7 -> 0 with no skipped channel.
REQ-019 Every grant SHALL be followed by at least one IDLE cycle; there are no back-to-back grants.
REQ-020 A new request arriving with the same edge as a release SHALL be arbitrated in the following IDLE cycle using the updated ptr.
REQ-021 done asserted while in IDLE SHALL be ignored.
REQ-022 y SHALL equal d[sel] registered one cycle after sampling while valid=1, and 0 while valid=0.
REQ-023 valid SHALL equal the OR-reduction of gnt at all times.

Reset
REQ-024 rst=1 at an edge SHALL set state=IDLE, gnt=0, sel=0, valid=0, y=0, timeout=0, ptr=0, and hold counter=0.
REQ-025 rst asserted in BUSY SHALL drop the grant at that edge, with no timeout pulse and no ptr advance.
REQ-026 rst SHALL take priority over every other input.

Configuration
REQ-027 Macro MUX_SCHED_TIMEOUT_EN defined: an 8-bit hold counter SHALL count BUSY cycles, starting at 1 on the first grant cycle; at count==MAX_HOLD with no other release pending, the block force-releases per REQ-017 and pulses timeout=1 for exactly one cycle.
REQ-028 When done or a req drop coincides with the timeout cycle, the normal release SHALL win and timeout SHALL stay 0.
REQ-029 Macro undefined: no counter SHALL exist, timeout SHALL be tied 0, and grants are unbounded.

Structure
REQ-030 Package mux_sched_pkg SHALL hold the NCH and SELW=3 constants, the state enum (IDLE, BUSY) and the MAX_HOLD default.
REQ-031 The rotating-priority search SHALL be sub-module rr_pick: combinational, inputs req[7:0] and ptr[2:0], outputs any and idx[2:0].

Verification
REQ-032 Reset, then req=8'h00 for 10 cycles -> gnt=0, sel=0, valid=0, y=0 throughout.
REQ-033 Reset, req=8'h81 held, done pulsed 2 cycles after each grant -> grants alternate ch0, ch7, ch0, with sel 0, 7, 0 and one IDLE cycle between grants.
REQ-034 Reset, req=8'hFF, done after each grant -> sel sequence 0,1,...,7,0 (wrap check).
REQ-035 Grant ch3 with d=8'h08, then d=8'h00 -> y=1 one cycle after grant, y=0 one cycle after d changes; drop req[3] -> valid=0 next edge.
REQ-036 With MUX_SCHED_TIMEOUT_EN and MAX_HOLD=4, req[5] held with no done -> gnt=8'h20 for 4 cycles, timeout pulse on the release edge, then regrant ch5 after 1 IDLE cycle; without the macro, gnt holds indefinitely.
REQ-037 rst pulsed during a ch6 grant -> all outputs 0 at that edge, and the next grant for req=8'h40 is ch6 searched from ptr=0.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared constants and the FSM state type for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int NCH          = 8;
    localparam int SELW         = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req bit at or after ptr, searching upward mod NCH.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        // Walk from the farthest offset down so the closest match to ptr is written last.
        for (int k = NCH - 1; k >= 0; k--) begin
            w_cand = ptr + SELW'(k);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin arbiter driving an 8:1 registered mux; optional hold timeout under MUX_SCHED_TIMEOUT_EN.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int NCH_P    = NCH,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH_P-1:0]  req,
    input  logic              done,
    input  logic [NCH_P-1:0]  d,
    output logic [NCH_P-1:0]  gnt,
    output logic [SELW-1:0]   sel,
    output logic              valid,
    output logic              y,
    output logic              timeout
);

    if (NCH_P != NCH) begin : g_bad_nch
        $error("mux_rr_sched supports only NCH=8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("mux_rr_sched MAX_HOLD must be within 2..255");
    end

    state_t            r_state;
    logic [NCH-1:0]    r_gnt;
    logic [SELW-1:0]   r_sel;
    logic [SELW-1:0]   r_ptr;
    logic              r_valid;
    logic              r_y;

    logic              w_any;
    logic [SELW-1:0]   w_idx;
    logic              w_norm_rel;
    logic              w_force_rel;
    logic              w_release;

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_norm_rel = done || !req[r_sel];
    assign w_release  = w_norm_rel || w_force_rel;

`ifdef MUX_SCHED_TIMEOUT_EN
    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    assign w_force_rel = (r_hold_cnt == 8'(MAX_HOLD));
    assign timeout     = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == IDLE) begin
                if (w_any) r_hold_cnt <= 8'd1;
            end else if (w_release) begin
                r_hold_cnt <= '0;
                // A coincident done or request drop is a normal release, not a timeout.
                r_timeout  <= !w_norm_rel;
            end else begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end
`else
    assign w_force_rel = 1'b0;
    assign timeout     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_y     <= 1'b0;
        end else begin
            r_y <= (r_state == BUSY && !w_release) ? d[r_sel] : 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= {{(NCH-1){1'b0}}, 1'b1} << w_idx;
                        r_sel   <= w_idx;
                        r_valid <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_ptr   <= r_sel + SELW'(1);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;
    assign y     = r_y;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched; timeout checks follow MUX_SCHED_TIMEOUT_EN.
module tb_mux_rr_sched;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       y;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    mux_rr_sched #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .d       (d),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .y       (y),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Expects a grant of ch s at the next edge, holds one cycle, then releases via done.
    task automatic grant_release(input string tag, input int s);
        logic [7:0] oh;
        oh = 8'h01 << s;
        tick(1);
        check({tag, "_gnt"}, {gnt, 5'(sel), valid}, {oh, 5'(s), 1'b1});
        tick(1);
        check({tag, "_hold"}, {gnt, valid}, {oh, 1'b1});
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check({tag, "_rel"}, {gnt, valid}, {8'h00, 1'b0});
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        d    = 8'h00;
        tick(2);
        rst = 1'b0;
        check("reset_outs", {gnt, sel, valid, y, timeout}, 32'h0);

        for (int i = 0; i < 10; i++)
            begin
                tick(1);
                check("idle_noreq", {gnt, sel, valid, y, timeout}, 32'h0);
            end

        // Two requesters alternate.
        do_reset();
        req = 8'h81;
        grant_release("alt0", 0);
        grant_release("alt7", 7);
        grant_release("alt0b", 0);

        // Full rotation with wrap back to ch0.
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) grant_release($sformatf("wrap%0d", i), i % 8);

        // Mux data path on ch3.
        do_reset();
        req = 8'h08;
        d   = 8'h08;
        tick(1);
        check("mux_grant", {gnt, 5'(sel), y}, {8'h08, 5'd3, 1'b0});
        tick(1);
        check("mux_y1", 32'(y), 32'd1);
        d = 8'h00;
        tick(1);
        check("mux_y0", 32'(y), 32'd0);
        req = 8'h00;
        tick(1);
        check("mux_drop", {gnt, valid, y}, {8'h00, 1'b0, 1'b0});

        // done while idle has no effect.
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("idle_done", {gnt, valid}, {8'h00, 1'b0});

        // Release and new request on the same edge; ptr is now 4.
        req = 8'h08;
        tick(1);
        check("same_edge_g3", 32'(sel), 32'd3);
        done = 1'b1;
        req  = 8'h0C;
        tick(1);
        done = 1'b0;
        check("same_edge_rel", 32'(valid), 32'd0);
        tick(1);
        check("same_edge_g2", {gnt, 5'(sel)}, {8'h04, 5'd2});
        req = 8'h00;
        tick(1);

        // Hold timeout on ch5.
        do_reset();
        req = 8'h20;
        tick(1);
        check("to_c1", {gnt, timeout}, {8'h20, 1'b0});
`ifdef MUX_SCHED_TIMEOUT_EN
        for (int i = 2; i <= 4; i++) begin
            tick(1);
            check($sformatf("to_c%0d", i), {gnt, timeout}, {8'h20, 1'b0});
        end
        tick(1);
        check("to_release", {gnt, valid, timeout}, {8'h00, 1'b0, 1'b1});
        tick(1);
        check("to_regrant", {gnt, valid, timeout}, {8'h20, 1'b1, 1'b0});
        tick(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("to_done_wins", {gnt, valid, timeout}, {8'h00, 1'b0, 1'b0});
`else
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("nohold_limit", {gnt, valid, timeout}, {8'h20, 1'b1, 1'b0});
        end
`endif
        req = 8'h00;
        tick(2);

        // Reset during a ch6 grant.
        do_reset();
        req = 8'h40;
        tick(1);
        check("rst6_grant", {gnt, 5'(sel)}, {8'h40, 5'd6});
        tick(1);
        d    = 8'h40;
        tick(1);
        check("rst6_y", 32'(y), 32'd1);
        rst  = 1'b1;
        done = 1'b1;
        tick(1);
        rst  = 1'b0;
        done = 1'b0;
        check("rst6_outs", {gnt, sel, valid, y, timeout}, 32'h0);
        tick(1);
        check("rst6_regrant", {gnt, 5'(sel), valid}, {8'h40, 5'd6, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
